// File: rtl/exc_seq_if.sv
// Sequencer-side bundle between the pipeline/CP0 request sources and the trap sequencer.
// The master drives stall and requests. The slave (exc_seq) drives flush/redirect controls.
interface exc_seq_if;
  logic        stall;
  logic        exe_overflow;
  logic        id_unknown;
  logic        id_syscall;
  logic        int_req;
  logic        id_eret;
  logic        status_bev;
  logic        cause_iv;
  logic [31:0] epc;

  logic        busy;
  logic        exc_take;
  logic [4:0]  exc_code;
  logic        flush_if;
  logic        flush_id;
  logic        flush_exe;
  logic        pc_redirect;
  logic [31:0] redirect_pc;

  modport master (
    output stall, exe_overflow, id_unknown, id_syscall, int_req, id_eret,
           status_bev, cause_iv, epc,
    input  busy, exc_take, exc_code, flush_if, flush_id, flush_exe,
           pc_redirect, redirect_pc
  );

  modport slave (
    input  stall, exe_overflow, id_unknown, id_syscall, int_req, id_eret,
           status_bev, cause_iv, epc,
    output busy, exc_take, exc_code, flush_if, flush_id, flush_exe,
           pc_redirect, redirect_pc
  );
endinterface

// File: rtl/exc_seq.sv
// Exception/interrupt sequencer: picks one trap or ERET per event by fixed priority,
// then holds stage flushes for DRAIN_CYCLES and redirects the IF-stage PC.
module exc_seq #(
  parameter logic [31:0] NORM_BASE    = 32'h8000_0000,
  parameter logic [31:0] BOOT_BASE    = 32'hBFC0_0200,
  parameter int          DRAIN_CYCLES = 2
) (
  input logic        clk,
  input logic        rst,
  exc_seq_if.slave   bus
);

  localparam logic [1:0] ST_IDLE     = 2'd0;
  localparam logic [1:0] ST_DRAIN    = 2'd1;
  localparam logic [1:0] ST_REDIRECT = 2'd2;

  localparam logic [3:0] DRAIN_LD = 4'(DRAIN_CYCLES);

  localparam logic [4:0] CODE_OV  = 5'h0C;
  localparam logic [4:0] CODE_RI  = 5'h0A;
  localparam logic [4:0] CODE_SYS = 5'h08;
  localparam logic [4:0] CODE_INT = 5'h00;

  logic [1:0]  state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        exe_mask_q, exe_mask_d;
  logic [4:0]  exc_code_q, exc_code_d;
  logic [31:0] redirect_pc_q, redirect_pc_d;
  logic        exc_take_q, exc_take_d;
  logic        busy_q, busy_d;
  logic        flush_if_q, flush_if_d;
  logic        flush_id_q, flush_id_d;
  logic        flush_exe_q, flush_exe_d;
  logic        pc_redirect_q, pc_redirect_d;

  logic        req_any;
  logic [4:0]  sel_code;
  logic        sel_exe;
  logic        sel_eret;
  logic        accept;

  // Interrupts with CAUSE.IV use the dedicated 0x200 vector; ERET returns to EPC.
  function automatic logic [31:0] vec_target(
    input logic        eret,
    input logic [4:0]  code,
    input logic        bev,
    input logic        iv,
    input logic [31:0] epc_val
  );
    logic [31:0] base;
    logic [31:0] offs;
    base = bev ? BOOT_BASE : NORM_BASE;
    offs = ((code == CODE_INT) && iv) ? 32'h0000_0200 : 32'h0000_0180;
    return eret ? epc_val : (base + offs);
  endfunction

  always_comb begin
    req_any  = bus.exe_overflow | bus.id_unknown | bus.id_syscall |
               bus.int_req | bus.id_eret;
    sel_code = CODE_INT;
    sel_exe  = 1'b0;
    sel_eret = 1'b0;
    if (bus.exe_overflow) begin
      sel_code = CODE_OV;
      sel_exe  = 1'b1;
    end else if (bus.id_unknown) begin
      sel_code = CODE_RI;
    end else if (bus.id_syscall) begin
      sel_code = CODE_SYS;
    end else if (bus.int_req) begin
      sel_code = CODE_INT;
    end else if (bus.id_eret) begin
      sel_code = CODE_INT;
      sel_eret = 1'b1;
    end
  end

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    exe_mask_d    = exe_mask_q;
    exc_code_d    = exc_code_q;
    redirect_pc_d = redirect_pc_q;
    accept        = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!bus.stall && req_any) begin
          accept        = 1'b1;
          state_d       = ST_DRAIN;
          cnt_d         = DRAIN_LD;
          exe_mask_d    = sel_exe;
          exc_code_d    = sel_code;
          redirect_pc_d = vec_target(sel_eret, sel_code, bus.status_bev,
                                     bus.cause_iv, bus.epc);
        end
      end
      ST_DRAIN: begin
        // Drain ignores stall; a zero count is treated as already expired.
        cnt_d = (cnt_q == 4'd0) ? 4'd0 : cnt_q - 4'd1;
        if (cnt_q <= 4'd1) begin
          state_d = ST_REDIRECT;
        end
      end
      ST_REDIRECT: begin
        if (!bus.stall) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = 4'd0;
      end
    endcase
  end

  always_comb begin
    exc_take_d    = accept;
    busy_d        = (state_d != ST_IDLE);
    flush_if_d    = (state_d == ST_DRAIN) || (state_d == ST_REDIRECT);
    flush_id_d    = (state_d == ST_DRAIN);
    flush_exe_d   = (state_d == ST_DRAIN) && exe_mask_d;
    pc_redirect_d = (state_d == ST_REDIRECT);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      cnt_q         <= 4'd0;
      exe_mask_q    <= 1'b0;
      exc_code_q    <= 5'd0;
      redirect_pc_q <= 32'd0;
      exc_take_q    <= 1'b0;
      busy_q        <= 1'b0;
      flush_if_q    <= 1'b0;
      flush_id_q    <= 1'b0;
      flush_exe_q   <= 1'b0;
      pc_redirect_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      exe_mask_q    <= exe_mask_d;
      exc_code_q    <= exc_code_d;
      redirect_pc_q <= redirect_pc_d;
      exc_take_q    <= exc_take_d;
      busy_q        <= busy_d;
      flush_if_q    <= flush_if_d;
      flush_id_q    <= flush_id_d;
      flush_exe_q   <= flush_exe_d;
      pc_redirect_q <= pc_redirect_d;
    end
  end

  assign bus.busy        = busy_q;
  assign bus.exc_take    = exc_take_q;
  assign bus.exc_code    = exc_code_q;
  assign bus.flush_if    = flush_if_q;
  assign bus.flush_id    = flush_id_q;
  assign bus.flush_exe   = flush_exe_q;
  assign bus.pc_redirect = pc_redirect_q;
  assign bus.redirect_pc = redirect_pc_q;

endmodule

// File: tb/tb_exc_seq.sv
// Directed bench for exc_seq: priority, vectors, ERET target capture, stall and async reset.
module tb_exc_seq;
  logic clk;
  logic rst;
  int   n_tests;
  int   n_fail;

  exc_seq_if bus ();

  exc_seq #(
    .NORM_BASE   (32'h8000_0000),
    .BOOT_BASE   (32'hBFC0_0200),
    .DRAIN_CYCLES(2)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic outs(input string tag, input logic take, input logic [4:0] code,
                      input logic fi, input logic fd, input logic fe,
                      input logic pr, input logic bsy);
    chk({tag, ".take"},  {31'd0, bus.exc_take},    {31'd0, take});
    chk({tag, ".code"},  {27'd0, bus.exc_code},    {27'd0, code});
    chk({tag, ".f_if"},  {31'd0, bus.flush_if},    {31'd0, fi});
    chk({tag, ".f_id"},  {31'd0, bus.flush_id},    {31'd0, fd});
    chk({tag, ".f_exe"}, {31'd0, bus.flush_exe},   {31'd0, fe});
    chk({tag, ".pcr"},   {31'd0, bus.pc_redirect}, {31'd0, pr});
    chk({tag, ".busy"},  {31'd0, bus.busy},        {31'd0, bsy});
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    rst = 1'b1;
    bus.stall = 1'b0; bus.exe_overflow = 1'b0; bus.id_unknown = 1'b0;
    bus.id_syscall = 1'b0; bus.int_req = 1'b0; bus.id_eret = 1'b0;
    bus.status_bev = 1'b0; bus.cause_iv = 1'b0; bus.epc = 32'd0;
    repeat (2) @(posedge clk);
    #1;
    outs("rst", 1'b0, 5'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("rst.rpc", bus.redirect_pc, 32'd0);
    rst = 1'b0;
    tick();

    // syscall, BEV=0
    bus.id_syscall = 1'b1;
    tick();
    outs("sys.n1", 1'b1, 5'h08, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
    bus.id_syscall = 1'b0;
    tick();
    outs("sys.n2", 1'b0, 5'h08, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
    tick();
    outs("sys.n3", 1'b0, 5'h08, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
    chk("sys.rpc", bus.redirect_pc, 32'h8000_0180);
    tick();
    outs("sys.n4", 1'b0, 5'h08, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

    // simultaneous overflow/syscall/int held across the whole sequence
    bus.exe_overflow = 1'b1; bus.id_syscall = 1'b1; bus.int_req = 1'b1;
    tick();
    outs("pri.n1", 1'b1, 5'h0C, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
    tick();
    outs("pri.n2", 1'b0, 5'h0C, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
    tick();
    outs("pri.n3", 1'b0, 5'h0C, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
    chk("pri.rpc", bus.redirect_pc, 32'h8000_0180);
    bus.exe_overflow = 1'b0; bus.id_syscall = 1'b0; bus.int_req = 1'b0;
    tick();
    outs("pri.n4", 1'b0, 5'h0C, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

    // interrupt vectors with BEV=1
    bus.status_bev = 1'b1; bus.cause_iv = 1'b1; bus.int_req = 1'b1;
    tick();
    outs("iv1.n1", 1'b1, 5'h00, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
    bus.int_req = 1'b0;
    repeat (2) tick();
    chk("iv1.pcr", {31'd0, bus.pc_redirect}, 32'd1);
    chk("iv1.rpc", bus.redirect_pc, 32'hBFC0_0400);
    tick();
    bus.cause_iv = 1'b0; bus.int_req = 1'b1;
    tick();
    bus.int_req = 1'b0;
    repeat (2) tick();
    chk("iv0.pcr", {31'd0, bus.pc_redirect}, 32'd1);
    chk("iv0.rpc", bus.redirect_pc, 32'hBFC0_0380);
    tick();
    bus.status_bev = 1'b0;

    // eret: EPC captured at accept, later EPC changes ignored
    bus.epc = 32'h0040_1234; bus.id_eret = 1'b1;
    tick();
    outs("eret.n1", 1'b1, 5'h00, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
    bus.id_eret = 1'b0; bus.epc = 32'd0;
    tick();
    tick();
    outs("eret.n3", 1'b0, 5'h00, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
    chk("eret.rpc", bus.redirect_pc, 32'h0040_1234);
    tick();

    // stall in IDLE blocks sampling
    bus.stall = 1'b1; bus.id_unknown = 1'b1;
    repeat (2) tick();
    outs("stl.idle", 1'b0, 5'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    bus.stall = 1'b0;
    tick();
    outs("stl.acc", 1'b1, 5'h0A, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
    bus.id_unknown = 1'b0;
    tick();
    bus.stall = 1'b1;
    tick();
    // three stalled REDIRECT cycles, then one unstalled
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("stl.pcr%0d", i), {31'd0, bus.pc_redirect}, 32'd1);
      chk($sformatf("stl.rpc%0d", i), bus.redirect_pc, 32'h8000_0180);
      if (i == 3) bus.stall = 1'b0;
      tick();
    end
    outs("stl.done", 1'b0, 5'h0A, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

    // async reset in the middle of DRAIN
    bus.id_syscall = 1'b1;
    tick();
    bus.id_syscall = 1'b0;
    chk("ar.pre", {31'd0, bus.busy}, 32'd1);
    #2;
    rst = 1'b1;
    #1;
    outs("ar.mid", 1'b0, 5'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("ar.rpc", bus.redirect_pc, 32'd0);
    #1;
    rst = 1'b0;
    tick();
    chk("ar.idle", {31'd0, bus.busy}, 32'd0);
    bus.id_syscall = 1'b1;
    tick();
    outs("ar.acc", 1'b1, 5'h08, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
    bus.id_syscall = 1'b0;
    repeat (2) tick();
    chk("ar.pcr", {31'd0, bus.pc_redirect}, 32'd1);
    chk("ar.rpc2", bus.redirect_pc, 32'h8000_0180);
    tick();
    chk("ar.end", {31'd0, bus.busy}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/exc_seq.md
# exc_seq

Exception/interrupt sequencer for the pipelined MIPS core. It samples the exception, interrupt and ERET requests that also feed the CP0 register file, and selects one per event by fixed priority. It then runs a flush/drain/redirect sequence and drives the IF-stage PC mux with the handler vector or the EPC return address. It sits between CP0 and the pipeline hazard/PC logic, and owns the one-event-at-a-time serialization of traps.

## Interface
Parameters:
- NORM_BASE, 32'h8000_0000, handler base when STATUS.BEV=0
- BOOT_BASE, 32'hBFC0_0200, handler base when STATUS.BEV=1
- DRAIN_CYCLES, 2, cycles flush is held before redirect; legal range 1..15

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- stall  in  1  pipeline stall; blocks sampling and holds redirect
- exe_overflow  in  1  EXE arithmetic overflow request
- id_unknown  in  1  ID reserved-instruction request
- id_syscall  in  1  ID syscall request
- int_req  in  1  qualified interrupt (CP0 INT output)
- id_eret  in  1  ID eret request
- status_bev  in  1  STATUS[22]
- cause_iv  in  1  CAUSE[23]
- epc  in  32  current EPC value
- busy  out  1  sequencer not idle
- exc_take  out  1  one-cycle pulse when an event is accepted
- exc_code  out  5  latched code of accepted event
- flush_if, flush_id, flush_exe  out  1 each  stage flush controls
- pc_redirect  out  1  PC mux select to redirect_pc
- redirect_pc  out  32  redirect target

## Operation
- States: IDLE, DRAIN, REDIRECT. The state, the counter and all outputs are registered.
- IDLE: sampling is enabled only when stall=0. Highest-priority request wins:
  - exe_overflow: code 5'h0C; flushes IF, ID, EXE.
  - id_unknown: code 5'h0A; flushes IF, ID.
  - id_syscall: code 5'h08; flushes IF, ID.
  - int_req: code 5'h00; flushes IF, ID.
  - id_eret: code 5'h00, with an eret flag set; flushes IF, ID.
- On accept in IDLE:
  - pulse exc_take
  - latch exc_code, flush mask and target
  - load the counter with DRAIN_CYCLES
  - go to DRAIN
- Target computation:
  - eret: target = epc, sampled at accept.
  - otherwise: base = status_bev ? BOOT_BASE : NORM_BASE; offset = (code==0 && cause_iv) ? 32'h200 : 32'h180; target = base + offset, 32-bit wraparound add.
- DRAIN:
  - drive flush_* from the latched mask
  - decrement the counter every cycle, independent of stall
  - counter reaching 0 moves to REDIRECT
- REDIRECT:
  - pc_redirect=1 and redirect_pc=target
  - flush_if=1, flush_id=0, flush_exe=0
  - stays in REDIRECT while stall=1; when stall=0, return to IDLE next cycle
- busy=1 in DRAIN and REDIRECT.
- Requests arriving while busy, or in IDLE with stall=1, are ignored and not queued. The source stage holds its request while stalled.
- Simultaneous requests: lower-priority ones are dropped; the flushed instruction re-raises if still valid.
- Reset, asynchronous at any point including mid-sequence:
  - state IDLE, counter 0
  - busy, exc_take, flush_*, pc_redirect = 0
  - exc_code = 0, redirect_pc = 0
- Counter is 4 bits.

## Timing
- Request sampled on edge N, in IDLE with stall=0:
  - exc_take=1 during cycle N+1 only
  - flush_* asserted cycles N+1 .. N+DRAIN_CYCLES
  - pc_redirect asserted from cycle N+DRAIN_CYCLES+1 until the first cycle with stall=0, inclusive
- Minimum event-to-event spacing is DRAIN_CYCLES+2 cycles.
- Next accept is possible at the edge ending the last REDIRECT cycle + 1.
- redirect_pc is stable for the whole REDIRECT interval.
- exc_code holds until the next accept.

## Test plan
- Reset, then id_syscall=1 for one cycle, bev=0, DRAIN=2 -> exc_take at N+1; flush_if/id=1 at N+1..N+2, flush_exe=0; pc_redirect at N+3 with redirect_pc=32'h8000_0180; exc_code=5'h08.
- exe_overflow and id_syscall and int_req asserted together -> single accept, exc_code=5'h0C, flush_exe=1; no second exc_take while busy.
- int_req with cause_iv=1, bev=1 -> redirect_pc=32'hBFC0_0400; with cause_iv=0 -> 32'hBFC0_0380.
- id_eret with epc=32'h0040_1234 -> flush_if/id only, redirect_pc=32'h0040_1234; epc changed to 0 during DRAIN does not change the target.
- stall cases:
  - stall=1 in IDLE with id_unknown=1 -> no accept; stall drops -> accept with code 5'h0A
  - stall=1 entering REDIRECT for 3 cycles -> pc_redirect held 4 cycles, then IDLE
- rst pulsed mid-DRAIN, asynchronously between edges -> all outputs 0 immediately; the next request is accepted normally.
